// File: rtl/pipeline_defs.sv
// Shared pipeline constants for the 5-stage MIPS core.
// Register-address width, the NOP used by flush/bubble, mult/div latency.
package pipeline_defs;

    localparam int          REG_AW            = 5;
    localparam logic [31:0] NOP_INSTR         = 32'h0;
    localparam int          MULDIV_CYCLES_DEF = 32;

endpackage

// File: rtl/hazard_controller_if.sv
// Hazard-controller bundle: ID/EX decode info in, stall/flush controls out.
// slave = hazard_controller, master = the pipeline side that drives it.
interface hazard_controller_if;
    import pipeline_defs::*;

    logic [REG_AW-1:0] IDrs;
    logic [REG_AW-1:0] IDrt;
    logic              IDusesrs;
    logic              IDusesrt;
    logic              IDjump;
    logic              IDmuldiv;
    logic              IDreadshilo;
    logic              EXmemread;
    logic [REG_AW-1:0] EXrt;
    logic              EXbranchtaken;

    logic              datahazard;
    logic              PCwrite;
    logic              IDEXbubble;
    logic              IFIDflush;
    logic              muldivstart;
    logic              muldivbusy;

    modport slave (
        input  IDrs, IDrt, IDusesrs, IDusesrt, IDjump,
        input  IDmuldiv, IDreadshilo,
        input  EXmemread, EXrt, EXbranchtaken,
        output datahazard, PCwrite, IDEXbubble, IFIDflush,
        output muldivstart, muldivbusy
    );

    modport master (
        output IDrs, IDrt, IDusesrs, IDusesrt, IDjump,
        output IDmuldiv, IDreadshilo,
        output EXmemread, EXrt, EXbranchtaken,
        input  datahazard, PCwrite, IDEXbubble, IFIDflush,
        input  muldivstart, muldivbusy
    );

endinterface

// File: rtl/hazard_controller_muldiv_scoreboard.sv
// Busy down-counter for the shared multi-cycle mult/div unit.
// Ports: clk, reset (sync, active-low), start (load), busy (cnt != 0).
module muldiv_scoreboard #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Start is only issued when idle, so load and decrement never collide.
    always_comb begin
        cnt_d = cnt_q;
        if (start)
            cnt_d = CNT_W'(MULDIV_CYCLES);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer: load-use, taken branch, jump and mult/div hazards.
// Ports: clk, reset (sync, active-low), hif (hazard_controller_if.slave).
module hazard_controller
    import pipeline_defs::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
    parameter int CNT_W         = 6
) (
    input  logic                clk,
    input  logic                reset,
    hazard_controller_if.slave  hif
);

    logic busy;
    logic loaduse;
    logic mdhaz;
    logic dh;
    logic bub;
    logic fl;
    logic st;

    muldiv_scoreboard #(
        .MULDIV_CYCLES (MULDIV_CYCLES),
        .CNT_W         (CNT_W)
    ) u_sb (
        .clk   (clk),
        .reset (reset),
        .start (st),
        .busy  (busy)
    );

    // $zero is never a real load destination.
    assign loaduse = hif.EXmemread && (hif.EXrt != '0) &&
                     ((hif.IDusesrs && (hif.IDrs == hif.EXrt)) ||
                      (hif.IDusesrt && (hif.IDrt == hif.EXrt)));

    assign mdhaz = busy && (hif.IDreadshilo || hif.IDmuldiv);

    // Flush outranks every stall: the stalled ID instruction is on the
    // wrong path. A stalled jump only flushes once the stall releases.
    always_comb begin
        dh  = 1'b0;
        bub = 1'b0;
        fl  = 1'b0;
        st  = 1'b0;
        if (!reset) begin
            bub = 1'b1;
            fl  = 1'b1;
        end else if (hif.EXbranchtaken) begin
            bub = 1'b1;
            fl  = 1'b1;
        end else if (loaduse || mdhaz) begin
            dh  = 1'b1;
            bub = 1'b1;
        end else if (hif.IDmuldiv) begin
            st  = 1'b1;
        end else if (hif.IDjump) begin
            fl  = 1'b1;
        end
    end

    assign hif.datahazard  = dh;
    assign hif.PCwrite     = ~dh;
    assign hif.IDEXbubble  = bub;
    assign hif.IFIDflush   = fl;
    assign hif.muldivstart = st;
    assign hif.muldivbusy  = busy;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: vector table, corner sequences, random run
// checked against a cycle-count reference model.
module tb_hazard_controller;

    localparam int MC = 32;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       jmp;
        logic       md;
        logic       hl;
        logic       mr;
        logic [4:0] ert;
        logic       br;
    } in_t;

    typedef struct packed {
        logic dh;
        logic pc;
        logic bub;
        logic fl;
        logic st;
        logic bz;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    hazard_controller_if hif ();

    hazard_controller #(.MULDIV_CYCLES(MC), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    // Model: the unit is busy in every cycle before ready_cyc.
    int ready_cyc = 0;

    function automatic in_t mk(bit r, bit [4:0] rs, bit [4:0] rt,
                               bit urs, bit urt, bit j, bit md, bit hl,
                               bit mr, bit [4:0] ert, bit br);
        in_t v;
        v.rst = r;  v.rs = rs;   v.rt = rt;
        v.urs = urs; v.urt = urt; v.jmp = j;
        v.md = md;  v.hl = hl;   v.mr = mr;
        v.ert = ert; v.br = br;
        return v;
    endfunction

    function automatic out_t ex(bit dh, bit pc, bit bub, bit fl,
                                bit st, bit bz);
        out_t o;
        o.dh = dh; o.pc = pc; o.bub = bub;
        o.fl = fl; o.st = st; o.bz = bz;
        return o;
    endfunction

    function automatic out_t ref_model(in_t v, bit busy);
        out_t o;
        bit   lu;
        bit   mh;
        o = ex(0, 1, 0, 0, 0, busy);
        lu = v.mr && (v.ert != 0) &&
             ((v.urs && v.rs == v.ert) || (v.urt && v.rt == v.ert));
        mh = busy && (v.hl || v.md);
        if (!v.rst) begin
            o.bub = 1; o.fl = 1;
        end else if (v.br) begin
            o.bub = 1; o.fl = 1;
        end else if (lu || mh) begin
            o.dh = 1; o.bub = 1;
        end else if (v.md) begin
            o.st = 1;
        end else if (v.jmp) begin
            o.fl = 1;
        end
        o.pc = !o.dh;
        return o;
    endfunction

    // Called just after a rising edge; checks at the falling edge.
    task automatic step(input in_t v, input out_t e_in, input bit use_m,
                        input string name);
        out_t got;
        out_t e;
        out_t m;
        reset             = v.rst;
        hif.IDrs          = v.rs;
        hif.IDrt          = v.rt;
        hif.IDusesrs      = v.urs;
        hif.IDusesrt      = v.urt;
        hif.IDjump        = v.jmp;
        hif.IDmuldiv      = v.md;
        hif.IDreadshilo   = v.hl;
        hif.EXmemread     = v.mr;
        hif.EXrt          = v.ert;
        hif.EXbranchtaken = v.br;
        #4;
        m = ref_model(v, cyc < ready_cyc);
        e = use_m ? m : e_in;
        got = ex(hif.datahazard, hif.PCwrite, hif.IDEXbubble,
                 hif.IFIDflush, hif.muldivstart, hif.muldivbusy);
        n_vec++;
        if (got !== e || (got.dh && got.fl) || (got.st && got.dh)) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got dh,pc,bub,fl,st,bz=%b want %b",
                     name, cyc, got, e);
        end
        @(posedge clk);
        if (!v.rst)
            ready_cyc = cyc + 1;
        else if (m.st)
            ready_cyc = cyc + 1 + MC;
        cyc++;
        #1;
    endtask

    in_t  idle;
    out_t nx;
    vec_t tbl[$];

    initial begin
        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nx   = ex(0, 1, 0, 0, 0, 0);
        reset = 1'b0;
        hif.IDrs = 0; hif.IDrt = 0; hif.IDusesrs = 0; hif.IDusesrt = 0;
        hif.IDjump = 0; hif.IDmuldiv = 0; hif.IDreadshilo = 0;
        hif.EXmemread = 0; hif.EXrt = 0; hif.EXbranchtaken = 0;
        repeat (2) @(posedge clk);
        #1;
        ready_cyc = 0;

        tbl.push_back({mk(0,0,0,0,0,0,0,0,0,0,0), ex(0,1,1,1,0,0)});
        tbl.push_back({idle,                      ex(0,1,0,0,0,0)});
        tbl.push_back({mk(1,8,0,1,0,0,0,0,1,8,0), ex(1,0,1,0,0,0)});
        tbl.push_back({mk(1,0,9,0,1,0,0,0,1,9,0), ex(1,0,1,0,0,0)});
        tbl.push_back({mk(1,8,0,0,1,0,0,0,1,8,0), ex(0,1,0,0,0,0)});
        tbl.push_back({mk(1,0,0,1,1,0,0,0,1,0,0), ex(0,1,0,0,0,0)});
        tbl.push_back({mk(1,8,8,1,1,0,0,0,0,8,0), ex(0,1,0,0,0,0)});
        tbl.push_back({mk(1,8,0,1,0,0,0,0,1,8,1), ex(0,1,1,1,0,0)});
        tbl.push_back({mk(1,0,0,0,0,0,1,0,0,0,1), ex(0,1,1,1,0,0)});
        tbl.push_back({idle,                      ex(0,1,0,0,0,0)});
        tbl.push_back({mk(1,0,0,0,0,1,0,0,0,0,0), ex(0,1,0,1,0,0)});
        tbl.push_back({mk(1,5,0,1,0,1,0,0,1,5,0), ex(1,0,1,0,0,0)});
        tbl.push_back({mk(1,0,0,0,0,0,0,1,0,0,0), ex(0,1,0,0,0,0)});
        tbl.push_back({mk(1,0,0,0,0,1,0,0,0,0,1), ex(0,1,1,1,0,0)});
        foreach (tbl[k])
            step(tbl[k].i, tbl[k].o, 0, $sformatf("table%0d", k));

        // Load-use lasts one cycle: the load leaves EX.
        step(mk(1,8,0,1,0,0,0,0,1,8,0), ex(1,0,1,0,0,0), 0, "lu_stall");
        step(mk(1,8,0,1,0,0,0,0,0,0,0), nx, 0, "lu_release");

        // Jump behind a load-use: stall first, then flush.
        step(mk(1,5,0,1,0,1,0,0,1,5,0), ex(1,0,1,0,0,0), 0, "jlu_stall");
        step(mk(1,5,0,1,0,1,0,0,0,0,0), ex(0,1,0,1,0,0), 0, "jlu_flush");
        step(idle, nx, 0, "jmp_once");

        // Mult/div start, then HI/LO reader from cycle 3.
        for (int k = 0; k <= 34; k++) begin
            bit b;
            bit d;
            b = (k >= 1 && k <= MC);
            d = (k >= 3 && k <= MC);
            step(mk(1,0,0,0,0,0,k==0,k>=3,0,0,0),
                 ex(d, !d, d, 0, k==0, b), 0, $sformatf("md_k%0d", k));
        end

        // Back-to-back mult/div: second waits until the counter drains.
        for (int k = 0; k <= 34; k++) begin
            bit b;
            bit d;
            b = (k >= 1 && k <= MC) || k == 34;
            d = (k >= 1 && k <= MC);
            step(mk(1,0,0,0,0,0,k<=33,0,0,0,0),
                 ex(d, !d, d, 0, k==0 || k==33, b), 0,
                 $sformatf("b2b_k%0d", k));
        end
        for (int k = 0; k < MC; k++)
            step(idle, nx, 1, "b2b_drain");

        // Reset mid-operation.
        for (int k = 0; k <= 13; k++) begin
            bit r;
            r = !(k == 10 || k == 11);
            if (!r)
                step(mk(0,0,0,0,0,0,0,0,0,0,0),
                     ex(0, 1, 1, 1, 0, k == 10), 0,
                     $sformatf("rst_k%0d", k));
            else
                step(mk(1,0,0,0,0,0,k==0,k>=12,0,0,0),
                     ex(0, 1, 0, 0, k==0, k >= 1 && k <= 9), 0,
                     $sformatf("rst_k%0d", k));
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            in_t v;
            v.rst = ($urandom_range(63) != 0);
            v.rs  = 5'($urandom_range(3));
            v.rt  = 5'($urandom_range(3));
            v.urs = 1'($urandom);
            v.urt = 1'($urandom);
            v.jmp = ($urandom_range(7) == 0);
            v.md  = ($urandom_range(9) == 0);
            v.hl  = ($urandom_range(5) == 0);
            v.mr  = ($urandom_range(2) == 0);
            v.ert = 5'($urandom_range(3));
            v.br  = ($urandom_range(7) == 0);
            step(v, nx, 1, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the IF/ID hold line (datahazard), the PC write enable, the ID/EX bubble and the IF/ID flush.
- Detects load-use hazards and taken branches/jumps.
- Schedules the shared multi-cycle mult/div unit with a busy counter, stalling ID when a HI/LO reader or second mult/div arrives while the unit is busy.
- Sits beside the ID stage, fed by ID-stage decode and EX-stage control.

Parameters:
- MULDIV_CYCLES, 32, cycles the mult/div unit needs from start until HI/LO are valid (must be ≥2).
- CNT_W, 6, counter width; must hold MULDIV_CYCLES.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- IDrs  in  5  rs field of the instruction in ID.
- IDrt  in  5  rt field of the instruction in ID.
- IDusesrs  in  1  ID instruction reads rs.
- IDusesrt  in  1  ID instruction reads rt.
- IDjump  in  1  ID instruction is j/jal/jr/jalr (target resolved in ID).
- IDmuldiv  in  1  ID instruction is mult/multu/div/divu.
- IDreadshilo  in  1  ID instruction is mfhi/mflo.
- EXmemread  in  1  EX instruction is a load.
- EXrt  in  5  destination of the load in EX.
- EXbranchtaken  in  1  branch in EX resolved taken.
- datahazard  out  1  hold IF/ID (connects to the IF/ID datahazard input).
- PCwrite  out  1  PC update enable (= ~datahazard).
- IDEXbubble  out  1  load a NOP into ID/EX next edge.
- IFIDflush  out  1  load a NOP into IF/ID next edge.
- muldivstart  out  1  one-cycle start pulse to the mult/div unit.
- muldivbusy  out  1  mult/div result not yet valid.

Behaviour:
- State is a single down-counter cnt (CNT_W bits). muldivbusy = (cnt != 0).
- All hazard outputs are combinational from the current inputs and cnt, so they are seen by the registers at the same rising edge.
- Synchronous reset (reset==0 at an edge):
  - cnt <= 0.
  - While reset is low: datahazard=0, PCwrite=1, IDEXbubble=1, IFIDflush=1, muldivstart=0.
  - Reset mid mult/div discards the operation; busy drops the cycle after the reset edge.
- Hazard terms:
  - loaduse = EXmemread & (EXrt!=0) & ((IDusesrs & IDrs==EXrt) | (IDusesrt & IDrt==EXrt)).
  - mdhaz = muldivbusy & (IDreadshilo | IDmuldiv).
- Priority, highest first:
  1. EXbranchtaken:
     - IFIDflush=1, IDEXbubble=1, datahazard=0.
     - No muldivstart; the mult/div in ID is squashed.
     - cnt keeps counting.
  2. loaduse:
     - datahazard=1, IDEXbubble=1, IFIDflush=0, muldivstart=0.
     - Exactly one stall cycle, because the load leaves EX next edge.
  3. mdhaz:
     - datahazard=1, IDEXbubble=1, muldivstart=0.
     - Held until the cycle in which cnt==0.
  4. IDmuldiv with cnt==0:
     - muldivstart=1 for one cycle.
     - cnt <= MULDIV_CYCLES at the edge.
     - No stall; the pipeline continues.
  5. IDjump:
     - IFIDflush=1 (squash the delay-fetched instruction); no stall.
  6. Otherwise: all hazard outputs 0, PCwrite=1.
- Counter rules:
  - If cnt != 0 and no start is issued, cnt decrements by 1 each cycle.
  - It never wraps below 0.
  - A start and a decrement never coincide (start requires cnt==0).
  - HI/LO are readable in the first cycle with cnt==0, MULDIV_CYCLES cycles after the start edge.
- Simultaneous events:
  - Flush beats any stall: the stalled ID instruction is on the wrong path.
  - A jump stalled by loaduse/mdhaz produces no flush until the stall releases.
- Invariants:
  - datahazard and IFIDflush are never both 1.
  - muldivstart implies !datahazard.

Decomposition:
- Shared package pipeline_defs holds:
  - the register-address width (5);
  - the NOP encoding 32'h0 used by flush/bubble;
  - MULDIV_CYCLES default.
- One sub-module is natural: muldiv_scoreboard. It holds the counter, start handling and busy output, with inputs start/reset and output busy.
- The top level holds hazard comparison and the priority mux.

Test Plan:
- Load-use:
  - Stimulus: EXmemread=1, EXrt=8, IDrs=8, IDusesrs=1.
  - Expect: datahazard=1, PCwrite=0, IDEXbubble=1 for exactly one cycle.
  - Repeat with EXrt=0: expect no stall.
- Mult/div scoreboard:
  - Stimulus: IDmuldiv=1 at cycle 0, then IDreadshilo=1 from cycle 3.
  - Expect: muldivstart pulse at cycle 0; busy cycles 1..32; datahazard=1 cycles 3..32; released at cycle 33 (MULDIV_CYCLES=32).
- Branch vs load-use:
  - Stimulus: EXbranchtaken=1 together with a loaduse match.
  - Expect: IFIDflush=1, IDEXbubble=1, datahazard=0.
  - Also IDmuldiv=1 with the branch: no muldivstart, cnt unchanged at 0.
- Jump:
  - Stimulus: IDjump=1 alone.
  - Expect: IFIDflush=1 for one cycle, datahazard=0.
  - Jump plus loaduse: a stall cycle first, then the flush.
- Reset mid-operation:
  - Stimulus: start a mult/div, assert reset=0 at cycle 10.
  - Expect: busy=0 from cycle 11; IFIDflush=IDEXbubble=1 while reset is low.
  - After release, IDreadshilo=1 causes no stall.
- Back-to-back mult/div:
  - Stimulus: second IDmuldiv at cycle 1.
  - Expect: stalled until cnt==0 (cycle 33), start pulse at cycle 33, cnt reloads to 32.
